// File: rtl/gpio_in_conditioner.sv
// GPIO pad input conditioning: two-flop synchronizer, per-pin stable-count debounce,
// edge detection into sticky W1C pending bits, registered interrupt and lowest-pin ID.
module gpio_in_conditioner #(
   parameter int unsigned NUM_PINS   = 32,
   parameter int unsigned DEBOUNCE_W = 8,
   localparam int unsigned IdW       = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_PINS-1:0]   gpio_in,
   input  logic [DEBOUNCE_W-1:0] cfg_debounce_i,
   input  logic [NUM_PINS-1:0]   cfg_rise_en_i,
   input  logic [NUM_PINS-1:0]   cfg_fall_en_i,
   input  logic [NUM_PINS-1:0]   irq_clr_i,
   output logic [NUM_PINS-1:0]   gpio_clean_o,
   output logic [NUM_PINS-1:0]   irq_pending_o,
   output logic                  irq_o,
   output logic [IdW-1:0]        irq_id_o,
   output logic                  irq_id_valid_o
);

   logic [NUM_PINS-1:0]   q1_q, q2_q;
   logic [NUM_PINS-1:0]   stable_q, stable_d;
   logic [DEBOUNCE_W-1:0] cnt_q [NUM_PINS];
   logic [DEBOUNCE_W-1:0] cnt_d [NUM_PINS];
   logic [NUM_PINS-1:0]   rise_evt, fall_evt;
   logic [NUM_PINS-1:0]   pending_q, pending_d;
   logic                  irq_q;
   logic [IdW-1:0]        irq_id_q, irq_id_d;

   // Counter holds the number of consecutive mismatching cycles already seen; a commit
   // happens on the cycle that would make it N+1.
   always_comb begin
      stable_d = stable_q;
      rise_evt = '0;
      fall_evt = '0;
      for (int i = 0; i < NUM_PINS; i++) begin
         cnt_d[i] = '0;
         if (q2_q[i] != stable_q[i]) begin
            if (cnt_q[i] >= cfg_debounce_i) begin
               stable_d[i] = q2_q[i];
               rise_evt[i] = q2_q[i];
               fall_evt[i] = ~q2_q[i];
            end else if (cnt_q[i] != {DEBOUNCE_W{1'b1}}) begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i];
            end
         end
      end
   end

   // Set has priority over a simultaneous clear.
   always_comb begin
      pending_d = (rise_evt & cfg_rise_en_i) | (fall_evt & cfg_fall_en_i) |
                  (pending_q & ~irq_clr_i);
   end

   always_comb begin
      irq_id_d = '0;
      for (int i = NUM_PINS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            irq_id_d = IdW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q1_q      <= '0;
         q2_q      <= '0;
         stable_q  <= '0;
         pending_q <= '0;
         irq_q     <= 1'b0;
         irq_id_q  <= '0;
         for (int i = 0; i < NUM_PINS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         q1_q      <= gpio_in;
         q2_q      <= q1_q;
         stable_q  <= stable_d;
         pending_q <= pending_d;
         irq_q     <= |pending_q;
         irq_id_q  <= irq_id_d;
         for (int i = 0; i < NUM_PINS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign gpio_clean_o   = stable_q;
   assign irq_pending_o  = pending_q;
   assign irq_o          = irq_q;
   assign irq_id_o       = irq_id_q;
   assign irq_id_valid_o = irq_q;

endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Input-conditioning stage between the GPIO pads and the APB GPIO register block. It synchronizes each asynchronous pad input, debounces it with a programmable stable-count filter, and detects rising and falling edges. Detected edges are latched into sticky, write-1-to-clear pending bits, which drive a registered interrupt and a lowest-pin-first interrupt ID. The conditioned levels replace the raw gpio_in bus seen by the register block, so software and the end-of-test handshake see glitch-free levels.

## Interface
- NUM_PINS, 32, number of GPIO pins handled
- DEBOUNCE_W, 8, width of the debounce threshold and of the per-pin counters
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- gpio_in  in  NUM_PINS  raw asynchronous pad inputs
- cfg_debounce_i  in  DEBOUNCE_W  stable-cycle threshold N, shared by all pins
- cfg_rise_en_i  in  NUM_PINS  per-pin rising-edge interrupt enable
- cfg_fall_en_i  in  NUM_PINS  per-pin falling-edge interrupt enable
- irq_clr_i  in  NUM_PINS  one-cycle write-1-to-clear strobe for the pending bits
- gpio_clean_o  out  NUM_PINS  debounced level, registered
- irq_pending_o  out  NUM_PINS  sticky pending bits, registered
- irq_o  out  1  registered OR of all pending bits
- irq_id_o  out  $clog2(NUM_PINS)  lowest pending pin index, registered
- irq_id_valid_o  out  1  irq_id_o is meaningful; equals irq_o

## Operation
- Sync: each pin passes through two flops, q1 then q2, both reset to 0. Only q2 is used downstream.
- Debounce, per pin: stable state s (reset 0) and counter cnt (reset 0).
  - When q2 == s: cnt <= 0.
  - When q2 != s and cnt >= cfg_debounce_i: s <= q2 and cnt <= 0.
  - When q2 != s otherwise: cnt <= cnt + 1. The counter saturates at all-ones and never wraps.
  - The >= comparison means that lowering the threshold mid-count commits on the next mismatching cycle.
  - N = 0 gives no filtering: s follows q2 one cycle later.
- Glitch rejection: a mismatch shorter than N+1 consecutive cycles never changes s, and a single matching cycle restarts the count.
- Edges: rise_evt is set when s commits 0->1; fall_evt is set when s commits 1->0. These are one-cycle, internal signals.
- Pending, per pin:
  - set = (rise_evt & cfg_rise_en_i) | (fall_evt & cfg_fall_en_i).
  - pending <= set | (pending & ~irq_clr_i).
  - When set and clear occur in the same cycle, set wins.
  - Disabling an enable does not clear an existing pending bit.
- Interrupt: irq_o <= |pending, and irq_id_o <= index of the lowest-numbered set pending bit (0 when none is set). Both register from the current pending vector.
- gpio_clean_o = s and irq_pending_o = pending, driven directly from the flops.
- Reset values: every output, flop and counter is 0.
- Power-up behaviour: a pad held high through reset produces a rising edge after reset deasserts. This is intended; software enables edges only after boot.

## Timing
- The pad changes before edge E0. q1 captures it at E0, q2 at E1, s commits at E(2+N), and the pending bit sets at E(2+N).
- irq_o and irq_id_o update at E(3+N).
- Worst-case extra latency of one cycle from metastability resolution in q1; the bench must tolerate E(2+N) or E(3+N).
- irq_clr_i at edge C clears pending at C. irq_o drops at C+1 unless another bit is pending or set at C.
- When rst is asserted mid-debounce, all counters and state clear at that edge. No edge event is generated by the reset itself.
- Opposing edges on the same pin with both enables set fold into the same sticky bit. Only one pending bit exists per pin.
- Throughput: each pin is independent. All pins may commit in the same cycle, and irq_id_o reports the lowest index.

## Test plan
- N=3, rise_en[4]=1, gpio_in[4] 0->1 held -> gpio_clean_o[4]=1 and irq_pending_o[4]=1 at E5; irq_o=1 and irq_id_o=4 at E6.
- N=3, gpio_in[4] glitch high for 3 cycles then low -> gpio_clean_o[4], pending and irq_o stay 0 throughout.
- N=0, rise_en[8]=1, fall_en[2]=1; pin 8 rises and pin 2 falls (from 1, after settling) at the same edge -> both pending bits set at E2 and irq_id_o=2. Pulsing irq_clr_i[2] moves irq_id_o to 8 one cycle later. Pulsing irq_clr_i[8] drops irq_o.
- Pending bit 5 set; a new enabled edge commits in the same cycle irq_clr_i[5] is asserted -> pending[5] remains 1.
- gpio_in[0]=1 held through rst -> after release, N=2: gpio_clean_o[0]=1 at E4. pending[0] is 1 only when rise_en[0]=1.
- N=200, assert rst after 100 mismatch cycles -> all outputs 0 at the next edge, and the count restarts from 0 after release.
